rmii_tx_framer: RTL and testbench



---
 rtl/eth_pkg.sv | 23 ++
 rtl/crc_gen.sv | 21 ++
 rtl/rmii_tx_framer.sv | 101 ++++++++++
 tb/tb_rmii_tx_framer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// eth_pkg: shared Ethernet transmit constants, framer state type and CRC32 bit step
package eth_pkg;
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PREAMBLE,
      ST_SFD,
      ST_DATA,
      ST_PAD,
      ST_FCS,
      ST_IFG
   } tx_state_t;

   localparam logic [1:0]  PREAMBLE_DIBIT  = 2'b01;
   localparam logic [7:0]  SFD_BYTE        = 8'hD5;
   localparam int          ETH_MIN_PAYLOAD = 60;
   localparam int          ETH_IFG_BYTES   = 12;
   localparam logic [31:0] CRC_POLY        = 32'hEDB88320;

   // Reflected CRC32, one serial bit in LSB-first wire order
   function automatic logic [31:0] crc_bit(input logic [31:0] c, input logic b);
      return (c >> 1) ^ ((c[0] ^ b) ? CRC_POLY : 32'h0);
   endfunction
endpackage

// File: rtl/crc_gen.sv
// crc_gen: dibit-serial Ethernet CRC32; Crc_Out is the inverted value including the current dibit
module crc_gen
   import eth_pkg::*;
(
   input  logic        Clk,
   input  logic        Rst,
   input  logic        Crc_En,
   input  logic [1:0]  Data,
   output logic [31:0] Crc_Out
);
   logic [31:0] crc, crc_nxt;

   always_comb begin
      crc_nxt = Crc_En ? crc_bit(crc_bit(crc, Data[0]), Data[1]) : crc;
      Crc_Out = ~crc_nxt;
   end

   always_ff @(posedge Clk or posedge Rst)
      if (Rst) crc <= 32'hFFFFFFFF;
      else crc <= crc_nxt;
endmodule

// File: rtl/rmii_tx_framer.sv
// rmii_tx_framer: builds Ethernet frames (preamble, SFD, payload, pad, FCS, IFG)
// and drives them onto RMII transmit one dibit per clock
module rmii_tx_framer
   import eth_pkg::*;
#(
   parameter int PREAMBLE_BYTES = 7,
   parameter int MIN_PAYLOAD    = ETH_MIN_PAYLOAD,
   parameter int IFG_BYTES      = ETH_IFG_BYTES
) (
   input  logic       Clk,
   input  logic       Rst,
   input  logic [7:0] Tx_Data,
   input  logic       Tx_Valid,
   input  logic       Tx_Last,
   output logic       Tx_Ready,
   output logic       Tx_En,
   output logic [1:0] Txd,
   output logic       Busy,
   output logic       Frame_Done,
   output logic       Underrun
);
   localparam int            CW       = $clog2(4 * ((PREAMBLE_BYTES > IFG_BYTES ? PREAMBLE_BYTES : IFG_BYTES) + 4));
   localparam logic [CW-1:0] PRE_LAST = CW'(4 * PREAMBLE_BYTES - 1);
   localparam logic [CW-1:0] IFG_LAST = CW'(4 * IFG_BYTES - 1);
   localparam logic [CW-1:0] FCS_LAST = CW'(15);
   localparam logic [11:0]   MIN_P    = 12'(MIN_PAYLOAD);

   tx_state_t     state, nxt;
   logic [CW-1:0] cnt;
   logic [1:0]    dib;
   logic [10:0]   bcnt, bsat;
   logic [31:0]   sh, sh_in, crc_out;
   logic          last_q, byte_end, pad_more, in_byte, crc_en, crc_rst, take, under;

   always_comb begin
      in_byte    = state == ST_SFD || state == ST_DATA || state == ST_PAD;
      crc_en     = state == ST_DATA || state == ST_PAD;
      crc_rst    = Rst || state == ST_PREAMBLE;
      byte_end   = dib == 2'd3;
      bsat       = &bcnt ? bcnt : bcnt + 11'd1;
      pad_more   = {1'b0, bsat} < MIN_P;
      Tx_Ready   = byte_end && (state == ST_SFD || (state == ST_DATA && !last_q));
      take       = Tx_Ready && Tx_Valid;
      under      = Tx_Ready && !Tx_Valid;
      Busy       = state != ST_IDLE;
      Frame_Done = state == ST_FCS && cnt == FCS_LAST;
   end

   always_comb begin
      nxt = state;
      case (state)
         ST_IDLE:     nxt = Tx_Valid ? ST_PREAMBLE : ST_IDLE;
         ST_PREAMBLE: nxt = cnt == PRE_LAST ? ST_SFD : ST_PREAMBLE;
         ST_SFD:      nxt = !byte_end ? ST_SFD : Tx_Valid ? ST_DATA : ST_IFG;
         ST_DATA:     nxt = !byte_end ? ST_DATA : !last_q ? (Tx_Valid ? ST_DATA : ST_IFG) : pad_more ? ST_PAD : ST_FCS;
         ST_PAD:      nxt = byte_end && !pad_more ? ST_FCS : ST_PAD;
         ST_FCS:      nxt = cnt == FCS_LAST ? ST_IFG : ST_FCS;
         ST_IFG:      nxt = cnt != IFG_LAST ? ST_IFG : Tx_Valid ? ST_PREAMBLE : ST_IDLE;
         default:     nxt = ST_IDLE;
      endcase
   end

   // One shift register feeds Txd: SFD byte, payload bytes and the FCS word all leave LSB dibit first
   always_comb
      sh_in = nxt == ST_PREAMBLE ? {30'd0, PREAMBLE_DIBIT} :
              nxt == ST_SFD && state != ST_SFD ? {24'd0, SFD_BYTE} :
              take ? {24'd0, Tx_Data} :
              nxt == ST_FCS && state != ST_FCS ? crc_out :
              nxt == ST_SFD || nxt == ST_DATA || nxt == ST_FCS ? sh : 32'd0;

   always_ff @(posedge Clk or posedge Rst)
      if (Rst) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         dib      <= 2'd0;
         bcnt     <= 11'd0;
         sh       <= 32'd0;
         last_q   <= 1'b0;
         Tx_En    <= 1'b0;
         Txd      <= 2'b00;
         Underrun <= 1'b0;
      end else begin
         state    <= nxt;
         cnt      <= nxt != state ? '0 : cnt + 1'b1;
         dib      <= in_byte ? dib + 2'd1 : 2'd0;
         bcnt     <= state == ST_SFD ? 11'd0 : crc_en && byte_end ? bsat : bcnt;
         sh       <= sh_in >> 2;
         last_q   <= take ? Tx_Last : last_q;
         Tx_En    <= nxt inside {ST_PREAMBLE, ST_SFD, ST_DATA, ST_PAD, ST_FCS};
         Txd      <= sh_in[1:0];
         Underrun <= under;
      end

   crc_gen u_crc (
      .Clk     (Clk),
      .Rst     (crc_rst),
      .Crc_En  (crc_en),
      .Data    (Txd),
      .Crc_Out (crc_out)
   );
endmodule

// File: tb/tb_rmii_tx_framer.sv
// tb_rmii_tx_framer: random and directed frames checked against a byte-level Ethernet frame model
module tb_rmii_tx_framer;
   typedef logic [1:0] dq_t[$];
   typedef logic [7:0] bq_t[$];
   typedef logic       lq_t[$];
   typedef struct packed { logic [7:0] d; logic l; } ent_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] data [2];
   logic       valid [2];
   logic       last [2];
   logic       rdy [2];
   logic       en [2];
   logic       busy [2];
   logic       fd [2];
   logic       ur [2];
   logic [1:0] txd [2];
   int         total = 0;
   int         bad = 0;
   ent_t       sq[$];
   lq_t        en_l, fd_l, ur_l, rdy_l, busy_l;
   dq_t        txd_l;

   always #5 clk = ~clk;

   rmii_tx_framer u_dut (
      .Clk(clk), .Rst(rst), .Tx_Data(data[0]), .Tx_Valid(valid[0]), .Tx_Last(last[0]),
      .Tx_Ready(rdy[0]), .Tx_En(en[0]), .Txd(txd[0]), .Busy(busy[0]),
      .Frame_Done(fd[0]), .Underrun(ur[0])
   );

   rmii_tx_framer #(.MIN_PAYLOAD(0)) u_np (
      .Clk(clk), .Rst(rst), .Tx_Data(data[1]), .Tx_Valid(valid[1]), .Tx_Last(last[1]),
      .Tx_Ready(rdy[1]), .Tx_En(en[1]), .Txd(txd[1]), .Busy(busy[1]),
      .Frame_Done(fd[1]), .Underrun(ur[1])
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      assert (got === want) else begin
         bad++;
         $error("FAIL %s: got 0x%0h want 0x%0h", tag, got, want);
      end
   endtask

   // Expected on-wire dibits for a whole frame: preamble, SFD, padded payload, FCS
   function automatic dq_t model(input bq_t p, input int minp);
      bq_t         b, f;
      dq_t         o;
      logic [31:0] c;
      logic [7:0]  x;
      b = p;
      c = 32'hFFFFFFFF;
      while (b.size() < minp) b.push_back(8'h00);
      foreach (b[i]) begin
         x = b[i];
         for (int k = 0; k < 8; k++) c = (c >> 1) ^ ((c[0] ^ x[k]) ? 32'hEDB88320 : 32'h0);
      end
      c = ~c;
      for (int k = 0; k < 7; k++) f.push_back(8'h55);
      f.push_back(8'hD5);
      foreach (b[i]) f.push_back(b[i]);
      for (int k = 0; k < 4; k++) f.push_back(c[8*k +: 8]);
      foreach (f[i]) begin
         x = f[i];
         for (int k = 0; k < 4; k++) o.push_back(x[2*k +: 2]);
      end
      return o;
   endfunction

   function automatic bq_t rnd(input int n);
      bq_t p;
      for (int i = 0; i < n; i++) p.push_back(8'($urandom));
      return p;
   endfunction

   function automatic int ones(input lq_t q);
      int n = 0;
      foreach (q[i]) if (q[i] === 1'b1) n++;
      return n;
   endfunction

   task automatic load(input bq_t p);
      foreach (p[i]) sq.push_back('{d: p[i], l: (i == p.size() - 1)});
   endtask

   task automatic clear_logs();
      en_l = {}; fd_l = {}; ur_l = {}; rdy_l = {}; busy_l = {}; txd_l = {};
   endtask

   // Serve the byte queue to DUT s for ncyc cycles; drop Tx_Valid at the drop_at-th Tx_Ready
   task automatic run(input int s, input int ncyc, input int drop_at);
      bit acc = 1'b0;
      int rc = 0;
      for (int c = 0; c < ncyc; c++) begin
         @(negedge clk);
         if (acc) void'(sq.pop_front());
         valid[s] = sq.size() > 0;
         data[s]  = 8'h00;
         last[s]  = 1'b0;
         if (sq.size() > 0) begin
            data[s] = sq[0].d;
            last[s] = sq[0].l;
         end
         en_l.push_back(en[s]);
         txd_l.push_back(txd[s]);
         fd_l.push_back(fd[s]);
         ur_l.push_back(ur[s]);
         rdy_l.push_back(rdy[s]);
         busy_l.push_back(busy[s]);
         acc = rdy[s] && valid[s];
         if (rdy[s]) begin
            rc++;
            if (rc == drop_at) begin
               sq.delete();
               valid[s] = 1'b0;
               acc = 1'b0;
            end
         end
      end
   endtask

   task automatic check_frame(input string tag, input int k, input dq_t e, input bit want_fd,
                              output int st, output int ln);
      int r = -1;
      int m = 0;
      st = -1;
      ln = 0;
      for (int i = 0; i < en_l.size(); i++) begin
         if (en_l[i] === 1'b1 && (i == 0 || en_l[i-1] !== 1'b1)) r++;
         if (en_l[i] === 1'b1 && r == k) begin
            if (st < 0) st = i;
            ln++;
         end
      end
      if (st < 0) st = 0;
      for (int i = 0; i < ln && i < e.size(); i++) if (txd_l[st+i] !== e[i]) m++;
      chk({tag, "_len"}, ln, e.size());
      chk({tag, "_dibits"}, m, 0);
      chk({tag, "_fd_end"}, 32'(fd_l[st+ln-1]), 32'(want_fd));
   endtask

   initial begin
      bq_t         p;
      dq_t         e;
      int          st, ln, st1, ln1, u, n, m;
      logic [31:0] f;
      for (int i = 0; i < 2; i++) begin
         data[i] = 8'h00; valid[i] = 1'b0; last[i] = 1'b0;
      end
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
         chk("rst_tx_en", 32'(en[i]), 0);
         chk("rst_txd", 32'(txd[i]), 0);
         chk("rst_ready", 32'(rdy[i]), 0);
         chk("rst_busy", 32'(busy[i]), 0);
         chk("rst_done", 32'(fd[i]), 0);
         chk("rst_underrun", 32'(ur[i]), 0);
      end
      @(negedge clk);
      rst = 1'b0;

      // "123456789" without padding
      p = {};
      for (int i = 0; i < 9; i++) p.push_back(8'h31 + 8'(i));
      clear_logs(); load(p); run(1, 160, 0);
      e = model(p, 0);
      check_frame("a", 0, e, 1'b1, st, ln);
      chk("a_rise", st, 1);
      chk("a_len_spec", ln, 84);
      f = 32'd0;
      for (int i = 0; i < 16; i++) f = f | (32'(txd_l[st+ln-16+i]) << (2*i));
      chk("a_fcs", f, 32'hCBF43926);
      chk("a_done_cnt", ones(fd_l), 1);
      chk("a_ready_cnt", ones(rdy_l), 9);
      chk("a_underrun_cnt", ones(ur_l), 0);

      // single byte, padded to minimum
      p = {8'hAA};
      clear_logs(); load(p); run(0, 360, 0);
      e = model(p, 60);
      check_frame("b", 0, e, 1'b1, st, ln);
      chk("b_len_spec", ln, 288);
      m = 0;
      for (int i = 0; i < 32; i++) if (txd_l[st+i] !== (i < 31 ? 2'b01 : 2'b11)) m++;
      chk("b_pre_sfd", m, 0);
      chk("b_idle_busy", 32'(busy_l[busy_l.size()-1]), 0);

      // underrun at the 3rd ready pulse
      p = rnd(20);
      clear_logs(); load(p); run(0, 140, 3);
      e = model(p, 60);
      e = e[0:39];
      check_frame("c", 0, e, 1'b0, st, ln);
      u = 0;
      foreach (ur_l[i]) if (ur_l[i] === 1'b1 && u == 0) u = i;
      chk("c_underrun_cnt", ones(ur_l), 1);
      chk("c_underrun_pos", u, st + 40);
      chk("c_en_before", 32'(en_l[u-1]), 1);
      chk("c_en_at", 32'(en_l[u]), 0);
      n = 0;
      for (int i = u; i < u + 48; i++) if (en_l[i] === 1'b0 && busy_l[i] === 1'b1) n++;
      chk("c_ifg_low", n, 48);
      chk("c_idle_after", 32'(busy_l[u+48]), 0);
      chk("c_done_cnt", ones(fd_l), 0);

      // back-to-back 64-byte frames
      p = rnd(64);
      e = model(p, 60);
      clear_logs(); load(p);
      p = rnd(64);
      load(p);
      run(0, 760, 0);
      check_frame("d0", 0, e, 1'b1, st, ln);
      e = model(p, 60);
      check_frame("d1", 1, e, 1'b1, st1, ln1);
      chk("d_gap", st1 - (st + ln), 48);
      m = 0;
      for (int i = st + ln; i < st1; i++) if (txd_l[i] !== 2'b00) m++;
      chk("d_gap_txd", m, 0);
      chk("d_done_cnt", ones(fd_l), 2);

      // reset in the middle of the FCS, then a clean frame
      p = rnd(64);
      clear_logs(); load(p); run(0, 294, 0);
      chk("e_in_fcs", 32'(en_l[293]), 1);
      sq.delete();
      valid[0] = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("e_rst_en", 32'(en[0]), 0);
      chk("e_rst_txd", 32'(txd[0]), 0);
      chk("e_rst_busy", 32'(busy[0]), 0);
      @(negedge clk);
      rst = 1'b0;
      chk("e_rst_done", 32'(fd[0]), 0);
      chk("e_rst_underrun", 32'(ur[0]), 0);
      p = rnd(30);
      clear_logs(); load(p); run(0, 360, 0);
      e = model(p, 60);
      check_frame("e", 0, e, 1'b1, st, ln);
      chk("e_underrun_cnt", ones(ur_l), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
